romram_arbiter: RTL

Shares the single external ROM/RAM (SDRAM) access port between the CPC core's memory interface and the supervisor CPU. It sits between `cpc_core`'s `romram_*` signals, the supervisor bus and the memory controller. Each access is granted with CPC priority and a bounded-starvation guarantee for the supervisor. It sequences one access at a time over a req/ack handshake and returns read data with a held-valid flag.

---
 rtl/romram_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/romram_arbiter.sv
// ============================================================================
// romram_arbiter: shares one ROM/RAM memory port between the CPC core and the
// supervisor CPU. CPC has priority; the supervisor has bounded starvation.
// Optional feature macro: ROMRAM_ARB_TIMEOUT_EN (memory-ack watchdog).
// Revision: 1.0
// ============================================================================
`default_nettype none

module romram_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] cpc_addr_i,
  input  logic [7:0]        cpc_data_i,
  output logic [7:0]        cpc_data_o,
  input  logic              cpc_enable_i,
  input  logic              cpc_rd_i,
  input  logic              cpc_wr_i,
  output logic              cpc_valid_o,
  input  logic [ADDR_W-1:0] sup_addr_i,
  input  logic [7:0]        sup_data_i,
  output logic [7:0]        sup_data_o,
  input  logic              sup_enable_i,
  input  logic              sup_rd_i,
  input  logic              sup_wr_i,
  output logic              sup_valid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_data_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPC  = 2'b01;
  localparam logic [1:0] GRANT_SUP  = 2'b10;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] skip_cnt;
  logic       cpc_req;
  logic       sup_req;
  logic       grant_cpc;
  logic       grant_sup;
  logic       ack_hit;
  logic       expire;
  logic       release_acc;
  logic       timer_hit;

  assign cpc_req = cpc_enable_i & (cpc_rd_i | cpc_wr_i);
  assign sup_req = sup_enable_i & (sup_rd_i | sup_wr_i);

`ifdef ROMRAM_ARB_TIMEOUT_EN
  logic [7:0] timer;

  // timer counts cycles spent in MEM; it is 0 on the first cycle mem_req_o is high
  always_ff @(posedge clk_i) begin
    if (reset_i || state != MEM) timer <= 8'd0;
    else                         timer <= timer + 8'd1;
  end

  assign timer_hit = (timer == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i)     err_o <= 1'b0;
    else if (expire) err_o <= 1'b1;
  end
`else
  assign timer_hit = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_cpc   = 1'b0;
    grant_sup   = 1'b0;
    ack_hit     = 1'b0;
    expire      = 1'b0;
    release_acc = 1'b0;
    case (state)
      IDLE: begin
        if (cpc_req && !(sup_req && skip_cnt >= STARVE_MAX)) grant_cpc = 1'b1;
        else if (sup_req)                                    grant_sup = 1'b1;
        if (grant_cpc || grant_sup) state_nxt = MEM;
      end
      MEM: begin
        // an ack on the expiry cycle still counts as a normal completion
        if (mem_ack_i) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (timer_hit) begin
          expire    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if ((grant_o == GRANT_CPC) ? !cpc_enable_i : !sup_enable_i) begin
          release_acc = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= 8'h00;
      grant_o     <= GRANT_NONE;
      cpc_data_o  <= 8'hFF;
      sup_data_o  <= 8'hFF;
      cpc_valid_o <= 1'b0;
      sup_valid_o <= 1'b0;
      skip_cnt    <= 4'd0;
    end else begin
      if (state == IDLE) begin
        if (!sup_req)       skip_cnt <= 4'd0;
        else if (grant_cpc) skip_cnt <= (skip_cnt == 4'hF) ? 4'hF : skip_cnt + 4'd1;
        else if (grant_sup) skip_cnt <= 4'd0;
      end

      if (grant_cpc) begin
        mem_req_o  <= 1'b1;
        mem_we_o   <= cpc_wr_i;
        mem_addr_o <= cpc_addr_i;
        mem_data_o <= cpc_data_i;
        grant_o    <= GRANT_CPC;
      end else if (grant_sup) begin
        mem_req_o  <= 1'b1;
        mem_we_o   <= sup_wr_i;
        mem_addr_o <= sup_addr_i;
        mem_data_o <= sup_data_i;
        grant_o    <= GRANT_SUP;
      end

      if (ack_hit || expire) begin
        mem_req_o <= 1'b0;
        if (grant_o == GRANT_CPC) begin
          cpc_valid_o <= 1'b1;
          if (!mem_we_o) cpc_data_o <= ack_hit ? mem_data_i : 8'hFF;
        end else begin
          sup_valid_o <= 1'b1;
          if (!mem_we_o) sup_data_o <= ack_hit ? mem_data_i : 8'hFF;
        end
      end

      if (release_acc) begin
        cpc_valid_o <= 1'b0;
        sup_valid_o <= 1'b0;
        grant_o     <= GRANT_NONE;
      end
    end
  end

endmodule

`default_nettype wire
